rijndael256_round_seq: RTL and testbench
========================================

# rijndael256_round_seq

Iterative round sequencer for 256-bit-block Rijndael encryption (Nb = 8, Nk = 8, Nr = 14). It holds the 256-bit cipher state and performs the initial AddRoundKey internally. It then feeds the state through an external combinational round datapath (SubBytes → ShiftRows → MixColumns, with MixColumns skipped on the last round) once per round, fetching one round key per round from the key schedule under a valid handshake. It sits between the block-level input/output handshakes and the shared round datapath built from the 256-bit round primitives.

## Interface
- NR, 14, number of rounds; legal range 1..15.
- RW, 4, width of round counter and key index; must satisfy 2^RW > NR.

- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start_valid  in  1  plaintext offered on din.
- start_ready  out  1  block accepts plaintext; high only in IDLE.
- din  in  256  plaintext block, column-major, byte 0 at [255:248].
- rk_req  out  1  round key requested for index rk_idx.
- rk_idx  out  RW  round-key index, 0..NR.
- rk_valid  in  1  rk holds key for rk_idx; ignored when rk_req low.
- rk  in  256  round key.
- rnd_state  out  256  current state presented to the round datapath (always equals internal state register).
- rnd_last  out  1  final round; the datapath must bypass MixColumns.
- rnd_result  in  256  combinational datapath result, without key addition.
- dout_valid  out  1  ciphertext available on dout.
- dout_ready  in  1  consumer accepts ciphertext.
- dout  out  256  ciphertext (equals state register in DONE, else 0).
- busy  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, KEY0, ROUND, DONE.
- IDLE: start_ready=1. On start_valid: state ← din, round ← 0, go to KEY0. start_valid in any other state is ignored; no capture occurs.
- KEY0: rk_req=1, rk_idx=0. On rk_valid: state ← state ^ rk, round ← 1, go to ROUND. Otherwise hold.
- ROUND: rk_req=1, rk_idx=round, rnd_last=(round==NR). On rk_valid: state ← rnd_result ^ rk. If round==NR, go to DONE; else round ← round+1. Otherwise hold all registers.
- DONE: dout_valid=1, dout=state, rk_req=0. On dout_ready: go to IDLE. dout stays stable while dout_ready is low.
- Outputs outside their state:
  - rk_req=0 in IDLE/DONE.
  - rk_idx=round in all states (0 in IDLE).
  - rnd_last=0 outside ROUND.
  - dout=0 outside DONE.
- Arithmetic: all key/round combination is 256-bit XOR. round never exceeds NR and never wraps.
- Reset (asynchronous, any state including mid-round):
  - State register and round are cleared to 0; FSM goes to IDLE.
  - Outputs: start_ready=1, busy=0, rk_req=0, rk_idx=0, rnd_last=0, dout_valid=0, dout=0, rnd_state=0.
  - Any partial result is discarded.

## Timing
- Accept edge E0 (start_valid & start_ready). KEY0 is active in the cycle after E0.
- With rk_valid held high:
  - KEY0 completes at E1.
  - Round r completes at E(1+r).
  - DONE is entered at E(NR+1) = E15, so dout_valid rises 15 edges after accept.
- Each low cycle of rk_valid during KEY0/ROUND adds exactly one cycle of latency.
- DONE→IDLE on the dout_ready edge. The earliest next accept is the following edge, so the minimum accept-to-accept period is NR+3 = 17 cycles.
- rnd_result is sampled on the same edge as rk; the datapath has zero cycles of latency.

## Test plan
- Identity datapath stub (rnd_result=rnd_state), rk={32{4'h0, rk_idx}}, rk_valid=1, dout_ready=1, din=0:
  - dout = {32{8'h0F}} (XOR of 0..14).
  - dout_valid rises exactly 15 edges after accept.
  - rnd_last is high only while rk_idx=14.
- Same stub, din=256'h_dbf201c6d42d01c6_130a01c6d42601c6_532201c6d43101c6_455c01c6d54c01c6:
  - dout = din ^ {32{8'h0F}}.
- rk_valid held low 3 cycles while rk_idx=5:
  - rk_idx stays 5.
  - rnd_state is unchanged during the stall.
  - dout_valid rises 18 edges after accept; dout unchanged from the no-stall result.
- dout_ready low 10 cycles in DONE:
  - dout_valid and dout hold stable; start_ready stays 0.
  - IDLE is entered on the edge where dout_ready=1.
- start_valid pulsed with din=all-ones while in ROUND:
  - No capture occurs; result matches the original din.
- rst_n asserted mid-cycle while round=7:
  - All outputs take their reset values immediately; start_ready=1 after release.
  - A fresh din=0 run produces {32{8'h0F}}.

Source files
------------

// File: rtl/rijndael256_round_seq.sv
// Iterative round sequencer for 256-bit-block Rijndael: holds the cipher state,
// applies the initial AddRoundKey and drives an external combinational round datapath.
module rijndael256_round_seq #(
  parameter int unsigned NR = 14,
  parameter int unsigned RW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_valid,
  output logic          start_ready,
  input  logic [255:0]  din,
  output logic          rk_req,
  output logic [RW-1:0] rk_idx,
  input  logic          rk_valid,
  input  logic [255:0]  rk,
  output logic [255:0]  rnd_state,
  output logic          rnd_last,
  input  logic [255:0]  rnd_result,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic [255:0]  dout,
  output logic          busy
);

  localparam logic [RW-1:0] LAST_RND = RW'(NR);
  localparam logic [RW-1:0] ONE      = RW'(1);

  typedef enum logic [1:0] {IDLE, KEY0, ROUND, DONE} fsm_t;

  fsm_t           fsm;
  logic [255:0]   st;
  logic [RW-1:0]  round;
  logic [255:0]   nxt_st;

  // Key addition on the datapath output; zero-latency datapath sampled with rk.
  assign nxt_st    = rnd_result ^ rk;
  assign rnd_state = st;
  assign rk_idx    = round;

  // Control flags are registered alongside the state transition they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm         <= IDLE;
      st          <= '0;
      round       <= '0;
      start_ready <= 1'b1;
      busy        <= 1'b0;
      rk_req      <= 1'b0;
      rnd_last    <= 1'b0;
      dout_valid  <= 1'b0;
      dout        <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (start_valid) begin
            fsm         <= KEY0;
            st          <= din;
            round       <= '0;
            start_ready <= 1'b0;
            busy        <= 1'b1;
            rk_req      <= 1'b1;
          end
        end
        KEY0: begin
          if (rk_valid) begin
            fsm      <= ROUND;
            st       <= st ^ rk;
            round    <= ONE;
            rnd_last <= (ONE == LAST_RND);
          end
        end
        ROUND: begin
          if (rk_valid) begin
            st <= nxt_st;
            if (round == LAST_RND) begin
              fsm        <= DONE;
              rk_req     <= 1'b0;
              rnd_last   <= 1'b0;
              dout_valid <= 1'b1;
              dout       <= nxt_st;
            end else begin
              round    <= round + ONE;
              rnd_last <= ((round + ONE) == LAST_RND);
            end
          end
        end
        DONE: begin
          if (dout_ready) begin
            fsm         <= IDLE;
            round       <= '0;
            start_ready <= 1'b1;
            busy        <= 1'b0;
            dout_valid  <= 1'b0;
            dout        <= '0;
          end
        end
        default: begin
          fsm         <= IDLE;
          start_ready <= 1'b1;
          busy        <= 1'b0;
          rk_req      <= 1'b0;
          rnd_last    <= 1'b0;
          dout_valid  <= 1'b0;
          dout        <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rijndael256_round_seq.sv
// Directed bench for rijndael256_round_seq with a stub round datapath and a
// synthetic key schedule (every key byte equals its round index).
module tb_rijndael256_round_seq;

  localparam int NR = 14;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_valid;
  logic          start_ready;
  logic [255:0]  din;
  logic          rk_req;
  logic [RW-1:0] rk_idx;
  logic          rk_valid;
  logic [255:0]  rk;
  logic [255:0]  rnd_state;
  logic          rnd_last;
  logic [255:0]  rnd_result;
  logic          dout_valid;
  logic          dout_ready;
  logic [255:0]  dout;
  logic          busy;
  logic          inv_last;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Stub datapath: identity, optionally inverting on the last round.
  assign rnd_result = (inv_last && rnd_last) ? ~rnd_state : rnd_state;
  assign rk         = {32{4'h0, rk_idx}};

  rijndael256_round_seq #(.NR(NR), .RW(RW)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_ready(start_ready), .din(din),
    .rk_req(rk_req), .rk_idx(rk_idx), .rk_valid(rk_valid), .rk(rk),
    .rnd_state(rnd_state), .rnd_last(rnd_last), .rnd_result(rnd_result),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout(dout), .busy(busy)
  );

  typedef struct {
    logic [255:0] din;
    logic         inv;
    int           stall_idx;
    int           stall_len;
    int           glitch_idx;
    int           hold;
    logic [255:0] exp_dout;
    int           exp_lat;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [255:0] key(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {32{b}};
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " start_ready"}, 256'(start_ready), 256'(1));
    chk({tag, " busy"}, 256'(busy), 256'(0));
    chk({tag, " rk_req"}, 256'(rk_req), 256'(0));
    chk({tag, " rk_idx"}, 256'(rk_idx), 256'(0));
    chk({tag, " rnd_last"}, 256'(rnd_last), 256'(0));
    chk({tag, " dout_valid"}, 256'(dout_valid), 256'(0));
    chk({tag, " dout"}, dout, 256'(0));
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [255:0] m_st;
    int exp_idx, edges, stalled;
    bit done, go, glitched;
    dout_ready = (v.hold > 0) ? 1'b0 : 1'b1;
    inv_last   = v.inv;
    chk({tag, " ready before accept"}, 256'(start_ready), 256'(1));
    din         = v.din;
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    m_st = v.din; exp_idx = 0; edges = 0; stalled = 0; done = 0; glitched = 0;
    while (!done && edges < 40) begin
      chk({tag, " rk_req"}, 256'(rk_req), 256'(1));
      chk({tag, " rk_idx"}, 256'(rk_idx), 256'(exp_idx));
      chk({tag, " rnd_last"}, 256'(rnd_last), 256'(exp_idx == NR));
      chk({tag, " rnd_state"}, rnd_state, m_st);
      chk({tag, " busy"}, 256'(busy), 256'(1));
      chk({tag, " start_ready"}, 256'(start_ready), 256'(0));
      chk({tag, " dout_valid early"}, 256'(dout_valid), 256'(0));
      chk({tag, " dout early"}, dout, 256'(0));
      go = !(exp_idx == v.stall_idx && stalled < v.stall_len);
      if (!go) stalled++;
      rk_valid = go;
      if (exp_idx == v.glitch_idx && !glitched) begin
        glitched    = 1;
        start_valid = 1'b1;
        din         = '1;
      end
      @(posedge clk); #1;
      edges++;
      start_valid = 1'b0;
      if (go) begin
        if (exp_idx == 0) m_st = m_st ^ key(0);
        else m_st = ((v.inv && exp_idx == NR) ? ~m_st : m_st) ^ key(exp_idx);
        if (exp_idx == NR) done = 1;
        else exp_idx++;
      end
    end
    rk_valid = 1'b1;
    chk({tag, " completed in budget"}, 256'(done), 256'(1));
    chk({tag, " latency"}, 256'(edges), 256'(v.exp_lat));
    chk({tag, " dout_valid"}, 256'(dout_valid), 256'(1));
    chk({tag, " dout"}, dout, v.exp_dout);
    chk({tag, " final rnd_state"}, rnd_state, v.exp_dout);
    chk({tag, " rk_req in done"}, 256'(rk_req), 256'(0));
    chk({tag, " rnd_last in done"}, 256'(rnd_last), 256'(0));
    chk({tag, " busy in done"}, 256'(busy), 256'(1));
    for (int h = 0; h < v.hold; h++) begin
      @(posedge clk); #1;
      chk({tag, " hold dout_valid"}, 256'(dout_valid), 256'(1));
      chk({tag, " hold dout"}, dout, v.exp_dout);
      chk({tag, " hold start_ready"}, 256'(start_ready), 256'(0));
    end
    dout_ready = 1'b1;
    @(posedge clk); #1;
    chk_idle_outputs({tag, " after done"});
  endtask

  initial begin
    logic [255:0] d2, d2x0f, d2xf0;
    d2    = 256'hdbf201c6d42d01c6_130a01c6d42601c6_532201c6d43101c6_455c01c6d54c01c6;
    d2x0f = 256'hd4fd0ec9db220ec9_1c050ec9db290ec9_5c2d0ec9db3e0ec9_4a530ec9da430ec9;
    d2xf0 = 256'h2b02f13624ddf136_e3faf13624d6f136_a3d2f13624c1f136_b5acf13625bcf136;
    //          din        inv  stall      glitch hold  expected          latency
    vecs[0] = '{256'(0),   1'b0, -1, 0,    -1,    0,    {32{8'h0F}},      15};
    vecs[1] = '{d2,        1'b0, -1, 0,    -1,    0,    d2x0f,            15};
    vecs[2] = '{256'(0),   1'b0,  5, 3,    -1,    0,    {32{8'h0F}},      18};
    vecs[3] = '{256'(0),   1'b0, -1, 0,    -1,    10,   {32{8'h0F}},      15};
    vecs[4] = '{256'(0),   1'b0, -1, 0,     6,    0,    {32{8'h0F}},      15};
    vecs[5] = '{'1,        1'b0, -1, 0,    -1,    0,    {32{8'hF0}},      15};
    vecs[6] = '{256'(0),   1'b1, -1, 0,    -1,    0,    {32{8'hF0}},      15};
    vecs[7] = '{d2,        1'b1,  0, 2,    -1,    0,    d2xf0,            17};

    rst_n = 1'b0; start_valid = 1'b0; din = '0; rk_valid = 1'b1;
    dout_ready = 1'b1; inv_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    chk("reset rnd_state", rnd_state, 256'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Asynchronous reset mid-cycle while round 7 is presented.
    inv_last = 1'b0; din = '0; rk_valid = 1'b1; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("pre-reset rk_idx", 256'(rk_idx), 256'(7));
    #3 rst_n = 1'b0;
    #1;
    chk_idle_outputs("async reset");
    chk("async reset rnd_state", rnd_state, 256'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post-reset start_ready", 256'(start_ready), 256'(1));
    run_vec(vecs[0], "fresh");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
